// File: rtl/full_adder_pkg.sv
// Shared constants and a plain-arithmetic reference for the full_adder datapath cell.
// fa_ref returns {cout, sum} with cout placed at bit 'width' and everything above cleared.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    function automatic logic [FA_MAX_WIDTH:0] fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin,
        input int unsigned             width
    );
        logic [FA_MAX_WIDTH:0] full;
        logic [FA_MAX_WIDTH:0] keep;
        full = {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
        // Shifting past the top bit wraps to zero, so width=64 keeps all 65 bits.
        keep = ({{FA_MAX_WIDTH{1'b0}}, 1'b1} << (width + 1)) - 1'b1;
        return full & keep;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder cell; chained by full_adder to form a ripple-carry adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH full_adder_cell instances with an optional output register.
// With REG_OUT=0 the result is purely combinational and clk/rst are ignored.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic [WIDTH-1:0] S,
    output logic             C_out
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH must be in 1..%0d", FA_MAX_WIDTH);
    end

    assign carry[0] = C_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        // Reset wins over loading, so a pending result is dropped when rst is high.
        always_ff @(posedge clk) begin
            if (rst) begin
                S     <= '0;
                C_out <= 1'b0;
            end else begin
                S     <= sum_comb;
                C_out <= carry[WIDTH];
            end
        end
    end else begin : g_comb
        assign S     = sum_comb;
        assign C_out = carry[WIDTH];
    end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: fixed vector table, hand-written corner sequences and randomized
// traffic checked against integer arithmetic, across WIDTH 1/4/8 registered and WIDTH 4 combinational.
module tb_full_adder;

    logic clk;
    logic rst;

    logic       a1, b1, c1, s1, co1;
    logic [3:0] a4, b4, s4;
    logic       c4, co4;
    logic [3:0] a4c, b4c, s4c;
    logic       c4c, co4c;
    logic [7:0] a8, b8, s8;
    logic       c8, co8;

    int compared;
    int mismatched;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .C_in(c1), .S(s1), .C_out(co1)
    );
    full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .C_in(c4), .S(s4), .C_out(co4)
    );
    full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4c (
        .clk(clk), .rst(rst), .A(a4c), .B(b4c), .C_in(c4c), .S(s4c), .C_out(co4c)
    );
    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .C_in(c8), .S(s8), .C_out(co8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       cin;
        logic [1:0] exp_cs;
    } vec_t;

    // Inputs are driven just after a falling edge; one rising edge loads them and
    // outputs are sampled on the following falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] model(input longint unsigned a, input longint unsigned b,
                                          input longint unsigned cin, input int width);
        longint unsigned total;
        total = a + b + cin;
        return 65'(total % (longint'(1) << (width + 1)));
    endfunction

    vec_t vecs[8];

    initial begin
        logic [64:0] exp1, exp4c, exp8;
        compared   = 0;
        mismatched = 0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b01};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b10};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 2'b10};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 2'b11};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 2'b01};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 2'b10};

        // Reset held for two cycles with all-ones inputs must still give zeros.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        a4c = 4'h0; b4c = 4'h0; c4c = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("reset_w1", 65'({co1, s1}), 65'd0);
            checkOutput("reset_w4", 65'({co4, s4}), 65'd0);
            checkOutput("reset_w8", 65'({co8, s8}), 65'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a1 = vecs[i].a; b1 = vecs[i].b; c1 = vecs[i].cin;
            applyStimulus();
            checkOutput($sformatf("table_w1[%0d]", i), 65'({co1, s1}), 65'(vecs[i].exp_cs));
        end

        // Reset at the same edge as 1+1+1 wins; the next non-reset edge loads it.
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; rst = 1'b1;
        applyStimulus();
        checkOutput("rst_priority_w1", 65'({co1, s1}), 65'd0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_release_w1", 65'({co1, s1}), 65'b11);

        a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
        applyStimulus();
        checkOutput("ripple_w4", 65'({co4, s4}), 65'h10);
        a4 = 4'h7; b4 = 4'h8; c4 = 1'b0;
        applyStimulus();
        checkOutput("no_carry_w4", 65'({co4, s4}), 65'h0F);
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        applyStimulus();
        checkOutput("all_ones_w4", 65'({co4, s4}), 65'h1F);
        a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
        applyStimulus();
        checkOutput("all_zero_w4", 65'({co4, s4}), 65'h00);
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        applyStimulus();
        checkOutput("ripple_w8", 65'({co8, s8}), 65'h100);

        // The combinational instance answers within the timestep and ignores rst.
        a4c = 4'h9; b4c = 4'h9; c4c = 1'b1;
        #1;
        checkOutput("comb_w4", 65'({co4c, s4c}), 65'h13);
        rst = 1'b1;
        a4c = 4'hF; b4c = 4'h0; c4c = 1'b1;
        #1;
        checkOutput("comb_ripple_rst_w4", 65'({co4c, s4c}), 65'h10);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            rst = ($urandom_range(0, 9) == 0);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            a4c = 4'($urandom); b4c = 4'($urandom); c4c = 1'($urandom);
            exp1  = rst ? 65'd0 : model(longint'(a1), longint'(b1), longint'(c1), 1);
            exp8  = rst ? 65'd0 : model(longint'(a8), longint'(b8), longint'(c8), 8);
            exp4c = model(longint'(a4c), longint'(b4c), longint'(c4c), 4);
            #1;
            checkOutput("rand_comb_w4", 65'({co4c, s4c}), exp4c);
            applyStimulus();
            checkOutput("rand_w1", 65'({co1, s1}), exp1);
            checkOutput("rand_w8", 65'({co8, s8}), exp8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
